// File: rtl/reg_file_reader_pkg.sv
// Shared widths and state encoding for the register-file dump engine.
package reg_file_reader_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DRAIN0,
    DRAIN1,
    FIN
  } state_t;

endpackage

// File: rtl/reg_file_reader.sv
// Dumps registers FIRST_REG..LAST_REG two at a time through a valid/ready
// stream, snapshotting each pair from the dual read ports in the FETCH cycle.
module reg_file_reader
  import reg_file_reader_pkg::*;
#(
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [REG_ADDR_W-1:0] addr1,
  output logic [REG_ADDR_W-1:0] addr2,
  input  logic [DATA_W-1:0]     rdout1,
  input  logic [DATA_W-1:0]     rdout2,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [REG_ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0]     out_data
);

  localparam logic [5:0] FIRST = 6'(FIRST_REG);
  localparam logic [5:0] LAST  = 6'(LAST_REG);

  state_t                state, state_nx;
  logic [5:0]            ptr, ptr_nx, ptr_p1, ptr_p2;
  logic [DATA_W-1:0]     buf0, buf1;
  logic [REG_ADDR_W-1:0] addr1_q, addr2_q, fetch_a2;

  // Six-bit pointer so ptr+2 past register 31 compares correctly against LAST.
  assign ptr_p1   = ptr + 6'd1;
  assign ptr_p2   = ptr + 6'd2;
  assign fetch_a2 = (ptr_p1 > 6'd31) ? 5'd31 : ptr_p1[4:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      buf0    <= '0;
      buf1    <= '0;
      addr1_q <= '0;
      addr2_q <= '0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
      if (state == FETCH) begin
        buf0    <= rdout1;
        buf1    <= rdout2;
        addr1_q <= ptr[4:0];
        addr2_q <= fetch_a2;
      end
    end
  end

  // Read addresses are live only in FETCH and otherwise replay the last fetch.
  always_comb begin
    state_nx  = state;
    ptr_nx    = ptr;
    busy      = 1'b0;
    done      = 1'b0;
    out_valid = 1'b0;
    out_addr  = ptr[4:0];
    out_data  = buf0;
    addr1     = addr1_q;
    addr2     = addr2_q;
    case (state)
      IDLE: begin
        if (start) begin
          ptr_nx   = FIRST;
          state_nx = FETCH;
        end
      end
      FETCH: begin
        busy     = 1'b1;
        addr1    = ptr[4:0];
        addr2    = fetch_a2;
        state_nx = DRAIN0;
      end
      DRAIN0: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nx = (ptr_p1 <= LAST) ? DRAIN1 : FIN;
      end
      DRAIN1: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_addr  = ptr_p1[4:0];
        out_data  = buf1;
        if (out_ready) begin
          ptr_nx   = ptr_p2;
          state_nx = (ptr_p2 <= LAST) ? FETCH : FIN;
        end
      end
      FIN: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_reg_file_reader.sv
// Bench for reg_file_reader: a behavioural dual-read register file feeds three
// instances (full range, 9..14, 31..31); cycle tables plus whole-dump sequences.
module tb_reg_file_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        ready;
  logic        start_v [3];
  logic        busy_v  [3];
  logic        done_v  [3];
  logic        valid_v [3];
  logic [4:0]  a1_v    [3];
  logic [4:0]  a2_v    [3];
  logic [4:0]  oa_v    [3];
  logic [31:0] rd1_v   [3];
  logic [31:0] rd2_v   [3];
  logic [31:0] od_v    [3];
  logic [31:0] regs    [32];
  logic [31:0] expv    [32];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_rf
    assign rd1_v[g] = regs[a1_v[g]];
    assign rd2_v[g] = regs[a2_v[g]];
  end

  reg_file_reader #(.FIRST_REG(0), .LAST_REG(31)) dut (
    .clk(clk), .rst(rst), .start(start_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .addr1(a1_v[0]), .addr2(a2_v[0]), .rdout1(rd1_v[0]), .rdout2(rd2_v[0]),
    .out_valid(valid_v[0]), .out_ready(ready), .out_addr(oa_v[0]), .out_data(od_v[0]));

  reg_file_reader #(.FIRST_REG(9), .LAST_REG(14)) dut_mid (
    .clk(clk), .rst(rst), .start(start_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .addr1(a1_v[1]), .addr2(a2_v[1]), .rdout1(rd1_v[1]), .rdout2(rd2_v[1]),
    .out_valid(valid_v[1]), .out_ready(ready), .out_addr(oa_v[1]), .out_data(od_v[1]));

  reg_file_reader #(.FIRST_REG(31), .LAST_REG(31)) dut_top (
    .clk(clk), .rst(rst), .start(start_v[2]), .busy(busy_v[2]), .done(done_v[2]),
    .addr1(a1_v[2]), .addr2(a2_v[2]), .rdout1(rd1_v[2]), .rdout2(rd2_v[2]),
    .out_valid(valid_v[2]), .out_ready(ready), .out_addr(oa_v[2]), .out_data(od_v[2]));

  typedef struct {
    logic        rst;
    logic        start;
    logic        rdy;
    logic        exp_valid;
    logic [4:0]  exp_oaddr;
    logic [31:0] exp_odata;
    logic        exp_busy;
    logic        exp_done;
    logic        chk_a;
    logic [4:0]  exp_a1;
    logic [4:0]  exp_a2;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] regInit(input int i);
    case (i)
      10:      return 32'h0000FFFF;
      14:      return 32'h0000FF00;
      31:      return 32'h0000AAAA;
      default: return 32'hC0DE0000 | 32'(i);
    endcase
  endfunction

  function automatic vec_t mk(input logic r, input logic s, input logic y, input logic v,
                              input int oa, input logic b, input logic d,
                              input logic ca, input int e1, input int e2);
    vec_t t;
    t.rst = r; t.start = s; t.rdy = y; t.exp_valid = v;
    t.exp_oaddr = 5'(oa); t.exp_odata = regInit(oa);
    t.exp_busy = b; t.exp_done = d; t.chk_a = ca;
    t.exp_a1 = 5'(e1); t.exp_a2 = 5'(e2);
    return t;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t t);
    @(negedge clk);
    rst        = t.rst;
    start_v[0] = t.start;
    ready      = t.rdy;
    #1;
  endtask

  task automatic snapshot();
    for (int i = 0; i < 32; i++) expv[i] = regs[i];
  endtask

  // Runs one complete dump on instance k with ready held high and checks
  // ordering, data, fetch addresses, latency, and single done pulse.
  task automatic runDump(input int k, input int first, input int last, input bit spam);
    int n, nbeats, nfetch, ndone, busy_after, first_beat, last_beat, done_c, fetch_first, post, nx;
    bit seen_done;
    n = last - first + 1;
    nbeats = 0; nfetch = 0; ndone = 0; busy_after = 0; post = 0;
    first_beat = -1; last_beat = -1; done_c = -1; fetch_first = -1; seen_done = 0;
    @(negedge clk);
    start_v[k] = 1'b1;
    ready      = 1'b1;
    @(negedge clk);
    start_v[k] = 1'b0;
    for (int c = 0; c < 200; c++) begin
      #1;
      if (busy_v[k] && !valid_v[k]) begin
        if (fetch_first < 0) fetch_first = c;
        nx = first + 2 * nfetch;
        checkOutput("fetch_addr1", 32'(a1_v[k]), 32'(nx));
        checkOutput("fetch_addr2", 32'(a2_v[k]), (nx + 1 > 31) ? 32'd31 : 32'(nx + 1));
        nfetch++;
      end
      if (valid_v[k]) begin
        if (first_beat < 0) first_beat = c;
        checkOutput("beat_addr", 32'(oa_v[k]), 32'(first + nbeats));
        checkOutput("beat_data", od_v[k], expv[(first + nbeats) & 31]);
        last_beat = c;
        nbeats++;
      end
      if (seen_done && busy_v[k]) busy_after++;
      if (done_v[k]) begin
        ndone++;
        done_c    = c;
        seen_done = 1'b1;
        if (spam) start_v[k] = 1'b1;
      end
      if (spam && c == 5) start_v[k] = 1'b1;
      if (seen_done) post++;
      if (post > 5) break;
      @(negedge clk);
      start_v[k] = 1'b0;
    end
    start_v[k] = 1'b0;
    checkOutput("beat_count", 32'(nbeats), 32'(n));
    checkOutput("fetch_count", 32'(nfetch), 32'((n + 1) / 2));
    checkOutput("done_pulses", 32'(ndone), 32'd1);
    checkOutput("busy_after_done", 32'(busy_after), 32'd0);
    checkOutput("fetch_latency", 32'(fetch_first), 32'd0);
    checkOutput("first_beat_latency", 32'(first_beat), 32'd1);
    checkOutput("done_after_last_beat", 32'(done_c), 32'(last_beat + 1));
    checkOutput("fetch_to_fin", 32'(done_c - fetch_first), 32'((n / 2) * 3 + (n % 2) * 2));
  endtask

  initial begin
    rst   = 1'b1;
    ready = 1'b0;
    for (int k = 0; k < 3; k++) start_v[k] = 1'b0;
    for (int i = 0; i < 32; i++) regs[i] = regInit(i);
    repeat (3) @(negedge clk);

    // Cycle table: start, 1/0/0/1 backpressure, stray start, reset in DRAIN1 of pair 4/5.
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 1, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 1, 1, 0, 1, 0, 1, 0, 1));
    vecs.push_back(mk(0, 1, 0, 1, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 1, 0, 1, 2, 3));
    vecs.push_back(mk(0, 0, 0, 1, 2, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 2, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 2, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 3, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 1, 0, 1, 4, 5));
    vecs.push_back(mk(0, 0, 1, 1, 4, 1, 0, 1, 4, 5));
    vecs.push_back(mk(1, 1, 1, 1, 5, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 1, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 1, 1, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 0, 1, 0, 1, 2, 3));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("v%0d_valid", i), 32'(valid_v[0]), 32'(vecs[i].exp_valid));
      checkOutput($sformatf("v%0d_busy", i), 32'(busy_v[0]), 32'(vecs[i].exp_busy));
      checkOutput($sformatf("v%0d_done", i), 32'(done_v[0]), 32'(vecs[i].exp_done));
      if (vecs[i].exp_valid) begin
        checkOutput($sformatf("v%0d_out_addr", i), 32'(oa_v[0]), 32'(vecs[i].exp_oaddr));
        checkOutput($sformatf("v%0d_out_data", i), od_v[0], vecs[i].exp_odata);
      end
      if (vecs[i].chk_a) begin
        checkOutput($sformatf("v%0d_addr1", i), 32'(a1_v[0]), 32'(vecs[i].exp_a1));
        checkOutput($sformatf("v%0d_addr2", i), 32'(a2_v[0]), 32'(vecs[i].exp_a2));
      end
    end

    snapshot();
    runDump(0, 0, 31, 1'b0);
    runDump(0, 0, 31, 1'b1);
    runDump(1, 9, 14, 1'b0);
    runDump(2, 31, 31, 1'b0);

    // Write reg 1 while beat 0 is stalled; buffered beat 1 must keep the old value.
    snapshot();
    @(negedge clk);
    start_v[0] = 1'b1;
    ready      = 1'b0;
    @(negedge clk);
    start_v[0] = 1'b0;
    #1;
    checkOutput("wr_fetch_busy", 32'(busy_v[0]), 32'd1);
    @(negedge clk);
    #1;
    checkOutput("wr_d0_valid", 32'(valid_v[0]), 32'd1);
    checkOutput("wr_d0_addr", 32'(oa_v[0]), 32'd0);
    regs[1] = 32'h00008888;
    @(negedge clk);
    #1;
    checkOutput("wr_stall_addr", 32'(oa_v[0]), 32'd0);
    checkOutput("wr_stall_data", od_v[0], expv[0]);
    ready = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("wr_beat1_addr", 32'(oa_v[0]), 32'd1);
    checkOutput("wr_beat1_data", od_v[0], 32'hC0DE0001);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("wr_reset_valid", 32'(valid_v[0]), 32'd0);

    snapshot();
    runDump(0, 0, 31, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
